instr_queue: RTL

Parametrised instruction queue between the fetch unit and the decode/issue stage of the RISC-V core. It buffers fetched instructions with their PCs in a power-of-two circular buffer, with valid/ready handshakes on both sides. It flushes in one cycle on a control-flow redirect and reports occupancy and almost-full so fetch can throttle before the queue fills.

---
 rtl/instr_queue_if.sv | 36 +++
 rtl/instr_queue.sv | 88 ++++++++
 2 files changed

// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for instr_queue: push side (in_*) and pop side (out_*).
// The master modport is the fetch/decode environment; the slave modport is the queue.
interface instr_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid,
        output in_instr,
        output in_pc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_pc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_pc
    );
endinterface

// File: rtl/instr_queue.sv
// Power-of-two circular instruction queue between fetch and decode.
// It supports a one-cycle flush, a global freeze (rdy_in), and occupancy/almost-full outputs.
module instr_queue #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    instr_queue_if.slave          bus,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  almost_full
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

    logic [XLEN-1:0]       instr_mem [DEPTH];
    logic [XLEN-1:0]       pc_mem    [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [CNT_W-1:0]      count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full  = (count_q == FULL_LEVEL);
        empty = (count_q == '0);
    end

    // Handshake outputs depend only on registered state and rdy_in.
    always_comb begin
        bus.in_ready  = rdy_in & ~full;
        bus.out_valid = rdy_in & ~empty;
        bus.out_instr = '0;
        bus.out_pc    = '0;
        if (bus.out_valid) begin
            bus.out_instr = instr_mem[head_q];
            bus.out_pc    = pc_mem[head_q];
        end
        count_out   = count_q;
        almost_full = (count_q >= AF_LEVEL);
    end

    always_comb begin
        push = bus.in_valid  & bus.in_ready;
        pop  = bus.out_valid & bus.out_ready;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + 1'b1;
                end
                if (pop) begin
                    head_q <= head_q + 1'b1;
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && push) begin
            instr_mem[tail_q] <= bus.in_instr;
            pc_mem[tail_q]    <= bus.in_pc;
        end
    end

    assert property (@(posedge clk_in) disable iff (!rst_in) count_q <= FULL_LEVEL);

endmodule
